// File: rtl/toy_bus_itcm_resp.sv
// ---------------------------------------------------------------------------
// toy_bus_itcm_resp
//
// This module is a bus target that wraps a DEPTH x 256-bit tightly coupled
// memory. Each accepted request produces exactly one ack. A single holding
// register stores the pending ack, so one transaction can complete per cycle
// while ack_rdy stays high.
//
// Parameters
//   DEPTH    number of 256-bit words (power of two, 2..1024)
//   NODE_ID  bus id of this target, returned on ack_src_id
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   req_vld/req_rdy   request handshake
//   req_addr          byte address; word index = req_addr[5 +: log2(DEPTH)]
//   req_strb          byte write enables for req_data
//   req_data          write data
//   req_opcode        0 = read, 1 = write
//   req_src_id        initiator id, returned on ack_tgt_id
//   req_tgt_id        addressed target id
//   req_sideband      opaque value, echoed on ack_sideband
//   ack_vld/ack_rdy   ack handshake
//   ack_opcode, ack_data, ack_sideband, ack_src_id, ack_tgt_id  ack fields
//   err_vld           one-cycle error pulse
//
// Optional feature
//   TOY_BUS_ITCM_RESP_CHK_EN  When this macro is defined, a request whose
//     target id does not match NODE_ID is flagged as an error. A request with
//     an address bit set above the word index is also flagged. A flagged
//     request is still acked, but it does not write memory, its ack_data is 0,
//     and err_vld pulses for one cycle. When the macro is undefined, err_vld
//     is tied to 0 and the index wraps modulo DEPTH.
// ---------------------------------------------------------------------------
module toy_bus_itcm_resp #(
  parameter int          DEPTH   = 64,
  parameter logic [3:0]  NODE_ID = 4'd0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_vld,
  output logic         req_rdy,
  input  logic [31:0]  req_addr,
  input  logic [31:0]  req_strb,
  input  logic [255:0] req_data,
  input  logic         req_opcode,
  input  logic [3:0]   req_src_id,
  input  logic [3:0]   req_tgt_id,
  input  logic [9:0]   req_sideband,
  output logic         ack_vld,
  input  logic         ack_rdy,
  output logic         ack_opcode,
  output logic [255:0] ack_data,
  output logic [9:0]   ack_sideband,
  output logic [3:0]   ack_src_id,
  output logic [3:0]   ack_tgt_id,
  output logic         err_vld
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [255:0]   mem_q [DEPTH];
  logic [IDX_W-1:0] idx;
  logic           req_xfer;
  logic           req_bad;
  logic           mem_we;

  logic           ack_opcode_q,   ack_opcode_d;
  logic [255:0]   ack_data_q,     ack_data_d;
  logic [9:0]     ack_sideband_q, ack_sideband_d;
  logic [3:0]     ack_src_q,      ack_src_d;
  logic [3:0]     ack_tgt_q,      ack_tgt_d;

  assign idx = req_addr[5 +: IDX_W];

  // A new request can enter when the holding register is empty, or when
  // it is being emptied in this same cycle.
  assign req_rdy  = (state_q == IDLE) | ack_rdy;
  assign req_xfer = req_vld & req_rdy;
  assign ack_vld  = (state_q == RESP);

`ifdef TOY_BUS_ITCM_RESP_CHK_EN
  logic unused_low_addr;
  logic err_q;

  // Any address bit above the word index, or a target id that does not
  // match this node, marks the request as misdirected.
  assign req_bad = (req_tgt_id != NODE_ID) | (|req_addr[31:5+IDX_W]);
  assign unused_low_addr = ^req_addr[4:0];

  // err_vld is high only in the cycle that follows acceptance of a
  // misdirected request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= req_xfer & req_bad;
    end
  end

  assign err_vld = err_q;
`else
  logic unused_addr_tgt;

  assign req_bad = 1'b0;
  assign unused_addr_tgt = ^{req_addr[4:0], req_addr[31:5+IDX_W], req_tgt_id};
  assign err_vld = 1'b0;
`endif

  // The memory write is gated with rst_n. This keeps a request that is
  // present during reset from corrupting the retained contents.
  assign mem_we = req_xfer & req_opcode & ~req_bad & rst_n;

  // The memory array has no reset. A read in the cycle after a write sees
  // the new data, because the write is complete at the previous edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 32; b++) begin
        if (req_strb[b]) begin
          mem_q[idx][8*b +: 8] <= req_data[8*b +: 8];
        end
      end
    end
  end

  // Next-state logic and ack-field capture. The ack fields change only on
  // request acceptance. This keeps them stable while the ack is back-pressured.
  always_comb begin
    state_d        = state_q;
    ack_opcode_d   = ack_opcode_q;
    ack_data_d     = ack_data_q;
    ack_sideband_d = ack_sideband_q;
    ack_src_d      = ack_src_q;
    ack_tgt_d      = ack_tgt_q;

    case (state_q)
      IDLE: if (req_xfer) state_d = RESP;
      RESP: begin
        if (req_xfer) begin
          state_d = RESP;
        end else if (ack_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (req_xfer) begin
      ack_opcode_d   = req_opcode;
      ack_data_d     = (req_opcode | req_bad) ? '0 : mem_q[idx];
      ack_sideband_d = req_sideband;
      ack_src_d      = NODE_ID;
      ack_tgt_d      = req_src_id;
    end
  end

  // State and the ack holding register. Reset discards any pending ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ack_opcode_q   <= 1'b0;
      ack_data_q     <= '0;
      ack_sideband_q <= '0;
      ack_src_q      <= '0;
      ack_tgt_q      <= '0;
    end else begin
      state_q        <= state_d;
      ack_opcode_q   <= ack_opcode_d;
      ack_data_q     <= ack_data_d;
      ack_sideband_q <= ack_sideband_d;
      ack_src_q      <= ack_src_d;
      ack_tgt_q      <= ack_tgt_d;
    end
  end

  assign ack_opcode   = ack_opcode_q;
  assign ack_data     = ack_data_q;
  assign ack_sideband = ack_sideband_q;
  assign ack_src_id   = ack_src_q;
  assign ack_tgt_id   = ack_tgt_q;

endmodule

// File: tb/tb_toy_bus_itcm_resp.sv
// ---------------------------------------------------------------------------
// tb_toy_bus_itcm_resp
//
// This is the testbench for toy_bus_itcm_resp. It contains a transaction-level
// reference model: a word array, one pending-ack record and an expected-error
// bit. The model advances once per clock from the bench's own inputs.
// Inputs are driven on the falling edge. Outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_toy_bus_itcm_resp;

  localparam int         DEPTH   = 64;
  localparam logic [3:0] NODE_ID = 4'd5;
`ifdef TOY_BUS_ITCM_RESP_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         req_vld;
  logic         req_rdy;
  logic [31:0]  req_addr;
  logic [31:0]  req_strb;
  logic [255:0] req_data;
  logic         req_opcode;
  logic [3:0]   req_src_id;
  logic [3:0]   req_tgt_id;
  logic [9:0]   req_sideband;
  logic         ack_vld;
  logic         ack_rdy;
  logic         ack_opcode;
  logic [255:0] ack_data;
  logic [9:0]   ack_sideband;
  logic [3:0]   ack_src_id;
  logic [3:0]   ack_tgt_id;
  logic         err_vld;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state.
  logic [255:0] mMem [DEPTH];
  bit           mPending;
  logic         mOp;
  logic [255:0] mData;
  logic [9:0]   mSb;
  logic [3:0]   mSrc;
  logic [3:0]   mTgt;
  bit           mErr;

  toy_bus_itcm_resp #(.DEPTH(DEPTH), .NODE_ID(NODE_ID)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr),
    .req_strb(req_strb), .req_data(req_data), .req_opcode(req_opcode),
    .req_src_id(req_src_id), .req_tgt_id(req_tgt_id), .req_sideband(req_sideband),
    .ack_vld(ack_vld), .ack_rdy(ack_rdy), .ack_opcode(ack_opcode),
    .ack_data(ack_data), .ack_sideband(ack_sideband),
    .ack_src_id(ack_src_id), .ack_tgt_id(ack_tgt_id), .err_vld(err_vld)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so that the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [255:0] randWord();
    return {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive one cycle's inputs just after the falling edge, then allow them
  // to settle before the caller samples.
  task automatic applyStimulus(input bit vld, input bit op, input logic [31:0] addr,
                               input logic [31:0] strb, input logic [255:0] data,
                               input logic [3:0] src, input logic [3:0] tgt,
                               input logic [9:0] sb, input bit ardy);
    req_vld      = vld;
    req_opcode   = op;
    req_addr     = addr;
    req_strb     = strb;
    req_data     = data;
    req_src_id   = src;
    req_tgt_id   = tgt;
    req_sideband = sb;
    ack_rdy      = ardy;
    #1;
  endtask

  task automatic applyIdle(input bit ardy);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, '0, 4'd0, NODE_ID, 10'd0, ardy);
  endtask

  // Advance the model by one rising edge, then wait for the next falling
  // edge. The handshakes are derived from the bench's own inputs and the
  // model's pending bit.
  task automatic advance();
    bit           accept;
    bit           bad;
    int           idx;
    logic [255:0] w;
    accept = req_vld && rst_n && (!mPending || ack_rdy);
    mErr   = 1'b0;
    if (accept) begin
      idx = int'((req_addr >> 5) % DEPTH);
      bad = CHK && ((req_tgt_id != NODE_ID) || ((req_addr >> 5) >= DEPTH));
      mOp  = req_opcode;
      mSb  = req_sideband;
      mTgt = req_src_id;
      mSrc = NODE_ID;
      mData = (req_opcode || bad) ? 256'd0 : mMem[idx];
      if (req_opcode && !bad) begin
        w = mMem[idx];
        for (int b = 0; b < 32; b++) begin
          if (req_strb[b]) w[8*b +: 8] = req_data[8*b +: 8];
        end
        mMem[idx] = w;
      end
      mErr     = bad;
      mPending = 1'b1;
    end else if (mPending && ack_rdy) begin
      mPending = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic modelReset();
    mPending = 1'b0;
    mOp      = 1'b0;
    mData    = '0;
    mSb      = '0;
    mSrc     = '0;
    mTgt     = '0;
    mErr     = 1'b0;
  endtask

  // Check the reset values of all outputs. Also confirm that a write
  // presented during reset is not accepted.
  task automatic test_reset();
    rst_n = 1'b0;
    applyIdle(1'b0);
    modelReset();
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 32'h0, '1, randWord(), 4'd1, NODE_ID, 10'h3, 1'b0);
    assertCount++;
    if (ack_vld !== 1'b0 || req_rdy !== 1'b1 || err_vld !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_handshake got vld=%b rdy=%b err=%b required 0 1 0", ack_vld, req_rdy, err_vld);
    end
    assertCount++;
    if (ack_opcode !== 1'b0 || ack_data !== 256'd0 || ack_sideband !== 10'd0 ||
        ack_src_id !== 4'd0 || ack_tgt_id !== 4'd0) begin
      failCount++;
      $display("[TB] FAIL reset_fields got op=%b sb=%h src=%h tgt=%h data=%h required all zero",
               ack_opcode, ack_sideband, ack_src_id, ack_tgt_id, ack_data);
    end
    advance();
    assertCount++;
    if (ack_vld !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_no_accept got ack_vld=%b required 0", ack_vld);
    end
    applyIdle(1'b1);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Write every word with a full strobe, back to back. Each ack must
  // arrive one cycle after its request.
  task automatic test_fill();
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) begin
        applyStimulus(1'b1, 1'b1, 32'(i) << 5, '1, randWord(), 4'($urandom_range(0, 15)),
                      NODE_ID, 10'($urandom_range(0, 1023)), 1'b1);
      end else begin
        applyIdle(1'b1);
      end
      if (i > 0) begin
        assertCount++;
        if (ack_vld !== 1'b1 || ack_opcode !== 1'b1 || ack_data !== 256'd0 ||
            ack_tgt_id !== mTgt || ack_sideband !== mSb || ack_src_id !== NODE_ID) begin
          failCount++;
          $display("[TB] FAIL fill_ack[%0d] got vld=%b op=%b tgt=%h sb=%h src=%h required 1 1 %h %h %h",
                   i, ack_vld, ack_opcode, ack_tgt_id, ack_sideband, ack_src_id, mTgt, mSb, NODE_ID);
        end
      end
      advance();
    end
  endtask

  // Cover a full write, a read-after-write in the next cycle, a single-byte
  // write, and a write with a zero strobe.
  task automatic test_directed();
    logic [255:0] d;
    d = randWord();
    applyStimulus(1'b1, 1'b1, 32'h40, 32'hFFFF_FFFF, d, 4'd2, NODE_ID, 10'h155, 1'b1);
    advance();
    applyStimulus(1'b1, 1'b0, 32'h40, 32'd0, '0, 4'd3, NODE_ID, 10'h0AA, 1'b1);
    assertCount++;
    if (ack_vld !== 1'b1 || ack_opcode !== 1'b1 || ack_data !== 256'd0 || ack_tgt_id !== 4'd2 ||
        ack_src_id !== NODE_ID || ack_sideband !== 10'h155) begin
      failCount++;
      $display("[TB] FAIL write_ack got vld=%b op=%b tgt=%h src=%h sb=%h required 1 1 2 %h 155",
               ack_vld, ack_opcode, ack_tgt_id, ack_src_id, ack_sideband, NODE_ID);
    end
    advance();
    applyStimulus(1'b1, 1'b1, 32'h40, 32'h0000_0001, 256'hAB, 4'd4, NODE_ID, 10'h001, 1'b1);
    assertCount++;
    if (ack_vld !== 1'b1 || ack_opcode !== 1'b0 || ack_data !== d || ack_tgt_id !== 4'd3) begin
      failCount++;
      $display("[TB] FAIL raw_read got vld=%b op=%b tgt=%h data=%h required 1 0 3 %h",
               ack_vld, ack_opcode, ack_tgt_id, ack_data, d);
    end
    advance();
    applyStimulus(1'b1, 1'b1, 32'h40, 32'd0, randWord(), 4'd6, NODE_ID, 10'h002, 1'b1);
    advance();
    applyStimulus(1'b1, 1'b0, 32'h40, 32'd0, '0, 4'd7, NODE_ID, 10'h003, 1'b1);
    assertCount++;
    if (ack_vld !== 1'b1 || ack_opcode !== 1'b1 || ack_data !== 256'd0 || ack_tgt_id !== 4'd6) begin
      failCount++;
      $display("[TB] FAIL zero_strb_ack got vld=%b op=%b tgt=%h required 1 1 6", ack_vld, ack_opcode, ack_tgt_id);
    end
    advance();
    applyIdle(1'b1);
    assertCount++;
    if (ack_data !== {d[255:8], 8'hAB}) begin
      failCount++;
      $display("[TB] FAIL byte_write got %h required %h", ack_data, {d[255:8], 8'hAB});
    end
    advance();
  endtask

  // Hold the ack for five cycles with a request waiting. Then release, so
  // that both handshakes happen in the same cycle.
  task automatic test_backpressure();
    applyStimulus(1'b1, 1'b0, 32'd9 << 5, 32'd0, '0, 4'd8, NODE_ID, 10'h2A5, 1'b1);
    advance();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd10 << 5, 32'd0, '0, 4'd9, NODE_ID, 10'h111, 1'b0);
      assertCount++;
      if (req_rdy !== 1'b0 || ack_vld !== 1'b1 || ack_data !== mMem[9] ||
          ack_tgt_id !== 4'd8 || ack_sideband !== 10'h2A5 || ack_opcode !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL stall[%0d] got rdy=%b vld=%b tgt=%h sb=%h data=%h required 0 1 8 2a5 %h",
                 i, req_rdy, ack_vld, ack_tgt_id, ack_sideband, ack_data, mMem[9]);
      end
      advance();
    end
    applyStimulus(1'b1, 1'b0, 32'd10 << 5, 32'd0, '0, 4'd9, NODE_ID, 10'h111, 1'b1);
    assertCount++;
    if (req_rdy !== 1'b1 || ack_vld !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL release got rdy=%b vld=%b required 1 1", req_rdy, ack_vld);
    end
    advance();
    applyIdle(1'b1);
    assertCount++;
    if (ack_vld !== 1'b1 || ack_data !== mMem[10] || ack_tgt_id !== 4'd9 || ack_sideband !== 10'h111) begin
      failCount++;
      $display("[TB] FAIL next_ack got vld=%b tgt=%h sb=%h data=%h required 1 9 111 %h",
               ack_vld, ack_tgt_id, ack_sideband, ack_data, mMem[10]);
    end
    advance();
    applyIdle(1'b1);
    assertCount++;
    if (ack_vld !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL drain got ack_vld=%b required 0", ack_vld);
    end
  endtask

  // Apply an asynchronous reset while an ack is pending. The ack must be
  // discarded and the memory contents must be kept.
  task automatic test_reset_mid();
    applyStimulus(1'b1, 1'b0, 32'd7 << 5, 32'd0, '0, 4'd1, NODE_ID, 10'h0F0, 1'b0);
    advance();
    applyStimulus(1'b1, 1'b1, 32'd7 << 5, '1, randWord(), 4'd2, NODE_ID, 10'h0F1, 1'b0);
    rst_n = 1'b0;
    #1;
    modelReset();
    assertCount++;
    if (ack_vld !== 1'b0 || req_rdy !== 1'b1 || ack_data !== 256'd0 || ack_tgt_id !== 4'd0) begin
      failCount++;
      $display("[TB] FAIL async_reset got vld=%b rdy=%b tgt=%h required 0 1 0", ack_vld, req_rdy, ack_tgt_id);
    end
    advance();
    advance();
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'd7 << 5, 32'd0, '0, 4'd3, NODE_ID, 10'h0F2, 1'b1);
    advance();
    applyIdle(1'b1);
    assertCount++;
    if (ack_vld !== 1'b1 || ack_data !== mMem[7]) begin
      failCount++;
      $display("[TB] FAIL retained got vld=%b data=%h required 1 %h", ack_vld, ack_data, mMem[7]);
    end
    advance();
  endtask

  // Write to an address above the index range, then read word 0 back.
  task automatic test_addr_check();
    applyStimulus(1'b1, 1'b1, 32'h0001_0000, '1, randWord(), 4'd4, NODE_ID, 10'h0C3, 1'b1);
    advance();
    applyStimulus(1'b1, 1'b0, 32'h0, 32'd0, '0, 4'd5, NODE_ID, 10'h0C4, 1'b1);
    assertCount++;
    if (ack_vld !== 1'b1 || ack_opcode !== 1'b1 || ack_data !== 256'd0 || err_vld !== CHK) begin
      failCount++;
      $display("[TB] FAIL high_addr_ack got vld=%b op=%b err=%b required 1 1 %b", ack_vld, ack_opcode, err_vld, CHK);
    end
    advance();
    applyIdle(1'b1);
    assertCount++;
    if (err_vld !== 1'b0 || ack_data !== mMem[0] || ack_vld !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL high_addr_read got err=%b vld=%b data=%h required 0 1 %h", err_vld, ack_vld, ack_data, mMem[0]);
    end
    advance();
  endtask

  // Run random traffic on a small set of words. Addresses sometimes have
  // high bits set, target ids sometimes do not match, and strobes vary.
  task automatic test_random();
    logic [31:0] addr;
    logic [31:0] strb;
    logic [3:0]  tgt;
    for (int c = 0; c < 600; c++) begin
      addr = (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) addr = addr | (32'($urandom_range(1, 255)) << 11);
      case ($urandom_range(0, 3))
        0:       strb = '1;
        1:       strb = 32'd0;
        default: strb = $urandom;
      endcase
      tgt = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : NODE_ID;
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), addr, strb, randWord(),
                    4'($urandom_range(0, 15)), tgt, 10'($urandom_range(0, 1023)),
                    $urandom_range(0, 2) != 0);
      assertCount++;
      if (ack_vld !== mPending || req_rdy !== (!mPending || ack_rdy) || err_vld !== mErr) begin
        failCount++;
        $display("[TB] FAIL rand_hs[%0d] got vld=%b rdy=%b err=%b required %b %b %b",
                 c, ack_vld, req_rdy, err_vld, mPending, (!mPending || ack_rdy), mErr);
      end
      if (mPending) begin
        assertCount++;
        if (ack_opcode !== mOp || ack_data !== mData || ack_sideband !== mSb ||
            ack_src_id !== mSrc || ack_tgt_id !== mTgt) begin
          failCount++;
          $display("[TB] FAIL rand_ack[%0d] got op=%b sb=%h src=%h tgt=%h data=%h required %b %h %h %h %h",
                   c, ack_opcode, ack_sideband, ack_src_id, ack_tgt_id, ack_data, mOp, mSb, mSrc, mTgt, mData);
        end
      end
      advance();
    end
    applyIdle(1'b1);
    advance();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_directed();
    test_backpressure();
    advance();
    test_reset_mid();
    test_addr_check();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
